// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller interface: D/X/M/W hazard inputs and the PC and pipeline-register controls.
// The TB/core side uses the master modport and the controller uses the slave modport.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
);
    logic [REG_W-1:0] d_src1;
    logic [REG_W-1:0] d_src2;
    logic             d_uses_src1;
    logic             d_uses_src2;
    logic             d_branch_taken;
    logic             d_halt;
    logic             x_mem_read;
    logic             x_reg_write;
    logic [REG_W-1:0] x_reg_dest;
    logic             imem_busy;
    logic             dmem_busy;
    logic             w_halt;

    logic             pc_wen;
    logic             fd_wen;
    logic             fd_flush;
    logic             dx_wen;
    logic             dx_flush;
    logic             xm_wen;
    logic             mw_wen;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output d_src1, d_src2, d_uses_src1, d_uses_src2, d_branch_taken, d_halt,
               x_mem_read, x_reg_write, x_reg_dest, imem_busy, dmem_busy, w_halt,
        input  pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen,
               halted, stall_cnt, flush_cnt
    );

    modport slave (
        input  d_src1, d_src2, d_uses_src1, d_uses_src2, d_branch_taken, d_halt,
               x_mem_read, x_reg_write, x_reg_dest, imem_busy, dmem_busy, w_halt,
        output pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen,
               halted, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, branch flush, memory-busy freeze, halt drain.
// Write enables are decoded combinationally from state and hazards; halted and the perf counters are registered.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_W = 4,
    parameter int unsigned CNT_W = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             halted_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu;
    logic run_eval;
    logic stall_inc, flush_inc;
    logic pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen;

    // Load-use: a load in X targets a nonzero register that the D instruction reads.
    always_comb begin
        lu = hz.x_mem_read && hz.x_reg_write && (hz.x_reg_dest != REG_W'(0)) &&
             ((hz.d_uses_src1 && (hz.d_src1 == hz.x_reg_dest)) ||
              (hz.d_uses_src2 && (hz.d_src2 == hz.x_reg_dest)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halted_q    <= (state_d == HALTED);
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        run_eval  = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        pc_wen    = 1'b0;
        fd_wen    = 1'b0;
        fd_flush  = 1'b0;
        dx_wen    = 1'b0;
        dx_flush  = 1'b0;
        xm_wen    = 1'b0;
        mw_wen    = 1'b0;

        unique case (state_q)
            RUN:    run_eval = 1'b1;
            DSTALL: begin
                // Resume in the same cycle the data access completes.
                if (!hz.dmem_busy) begin
                    state_d  = RUN;
                    run_eval = 1'b1;
                end
            end
            DRAIN: begin
                if (!hz.dmem_busy) begin
                    fd_wen   = 1'b1;
                    fd_flush = 1'b1;
                    dx_wen   = 1'b1;
                    xm_wen   = 1'b1;
                    mw_wen   = 1'b1;
                    if (hz.w_halt) state_d = HALTED;
                end
            end
            HALTED: ;
            default: state_d = RUN;
        endcase

        if (run_eval) begin
            if (hz.dmem_busy) begin
                state_d = DSTALL;
            end else if (lu) begin
                dx_wen    = 1'b1;
                dx_flush  = 1'b1;
                xm_wen    = 1'b1;
                mw_wen    = 1'b1;
                stall_inc = 1'b1;
            end else begin
                fd_wen = 1'b1;
                dx_wen = 1'b1;
                xm_wen = 1'b1;
                mw_wen = 1'b1;
                if (hz.imem_busy) begin
                    // The fetch bubble already covers a redirect, so a taken branch still loads the PC.
                    fd_flush  = 1'b1;
                    stall_inc = 1'b1;
                    pc_wen    = hz.d_branch_taken;
                    flush_inc = hz.d_branch_taken;
                    if (!hz.d_branch_taken && hz.d_halt) state_d = DRAIN;
                end else if (hz.d_branch_taken) begin
                    pc_wen    = 1'b1;
                    fd_flush  = 1'b1;
                    flush_inc = 1'b1;
                end else if (hz.d_halt) begin
                    fd_flush = 1'b1;
                    state_d  = DRAIN;
                end else begin
                    pc_wen = 1'b1;
                end
            end
        end

        if (rst) begin
            pc_wen   = 1'b0;
            fd_wen   = 1'b0;
            fd_flush = 1'b0;
            dx_wen   = 1'b0;
            dx_flush = 1'b0;
            xm_wen   = 1'b0;
            mw_wen   = 1'b0;
        end
    end

    // Saturating performance counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (flush_inc && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    assign hz.pc_wen    = pc_wen;
    assign hz.fd_wen    = fd_wen;
    assign hz.fd_flush  = fd_flush;
    assign hz.dx_wen    = dx_wen;
    assign hz.dx_flush  = dx_flush;
    assign hz.xm_wen    = xm_wen;
    assign hz.mw_wen    = mw_wen;
    assign hz.halted    = halted_q;
    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
// Control vector order: {pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, xm_wen, mw_wen}.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned REG_W = 4;
    localparam int unsigned CNT_W = 16;

    localparam logic [6:0] W_NONE   = 7'b000_0000;
    localparam logic [6:0] W_RUN    = 7'b110_1011;
    localparam logic [6:0] W_LU     = 7'b000_1111;
    localparam logic [6:0] W_BUBBLE = 7'b011_1011;
    localparam logic [6:0] W_BRANCH = 7'b111_1011;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipeline_hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz ();

    pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
    );

    logic [6:0] wens;
    assign wens = {hz.pc_wen, hz.fd_wen, hz.fd_flush, hz.dx_wen, hz.dx_flush, hz.xm_wen, hz.mw_wen};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.d_src1         = '0;
        hz.d_src2         = '0;
        hz.d_uses_src1    = 1'b0;
        hz.d_uses_src2    = 1'b0;
        hz.d_branch_taken = 1'b0;
        hz.d_halt         = 1'b0;
        hz.x_mem_read     = 1'b0;
        hz.x_reg_write    = 1'b0;
        hz.x_reg_dest     = '0;
        hz.imem_busy      = 1'b0;
        hz.dmem_busy      = 1'b0;
        hz.w_halt         = 1'b0;
    endtask

    // LDR r<dest> in X, D instruction reads src2.
    task automatic load_use(input logic [REG_W-1:0] dest, input logic [REG_W-1:0] src2, input logic uses2);
        hz.x_mem_read  = 1'b1;
        hz.x_reg_write = 1'b1;
        hz.x_reg_dest  = dest;
        hz.d_src2      = src2;
        hz.d_uses_src2 = uses2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        rst = 1'b1;
        tick();
        #1;
        check("rst_wens", 32'(wens), 32'(W_NONE));
        check("rst_halted", 32'(hz.halted), 32'd0);
        check("rst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        rst = 1'b0;
        #1;
        check("run_default", 32'(wens), 32'(W_RUN));

        // Load-use stall, then resume.
        load_use(4'd3, 4'd3, 1'b1);
        #1 check("lu_stall", 32'(wens), 32'(W_LU));
        tick();
        idle();
        #1 check("lu_resume", 32'(wens), 32'(W_RUN));
        check("lu_stall_cnt", 32'(hz.stall_cnt), 32'd1);

        // r0 and unused source never stall.
        load_use(4'd0, 4'd0, 1'b1);
        #1 check("lu_r0", 32'(wens), 32'(W_RUN));
        tick();
        load_use(4'd3, 4'd3, 1'b0);
        #1 check("lu_unused", 32'(wens), 32'(W_RUN));
        tick();
        idle();
        #1 check("lu_none_cnt", 32'(hz.stall_cnt), 32'd1);

        // Three separate taken branches.
        for (int i = 0; i < 3; i++) begin
            hz.d_branch_taken = 1'b1;
            #1 check("branch", 32'(wens), 32'(W_BRANCH));
            tick();
            idle();
            tick();
        end
        check("branch_flush_cnt", 32'(hz.flush_cnt), 32'd3);

        // Load-use wins over branch; branch honoured next cycle.
        load_use(4'd5, 4'd5, 1'b1);
        hz.d_branch_taken = 1'b1;
        #1 check("lu_over_branch", 32'(wens), 32'(W_LU));
        tick();
        check("lu_br_flush_hold", 32'(hz.flush_cnt), 32'd3);
        idle();
        hz.d_branch_taken = 1'b1;
        #1 check("branch_after_lu", 32'(wens), 32'(W_BRANCH));
        tick();
        idle();
        check("lu_br_flush_cnt", 32'(hz.flush_cnt), 32'd4);
        check("lu_br_stall_cnt", 32'(hz.stall_cnt), 32'd2);

        // Instruction fetch stall, alone and with a taken branch.
        hz.imem_busy = 1'b1;
        #1 check("imem_stall", 32'(wens), 32'(W_BUBBLE));
        tick();
        hz.d_branch_taken = 1'b1;
        #1 check("imem_branch", 32'(wens), 32'(W_BRANCH));
        tick();
        idle();
        check("imem_stall_cnt", 32'(hz.stall_cnt), 32'd4);
        check("imem_flush_cnt", 32'(hz.flush_cnt), 32'd5);

        // Data memory freeze for 4 cycles, load-use appearing in cycle 2.
        for (int i = 0; i < 4; i++) begin
            hz.dmem_busy = 1'b1;
            if (i >= 1) load_use(4'd7, 4'd7, 1'b1);
            #1 check("dmem_freeze", 32'(wens), 32'(W_NONE));
            tick();
        end
        hz.dmem_busy = 1'b0;
        #1 check("dmem_resume_lu", 32'(wens), 32'(W_LU));
        tick();
        idle();
        #1 check("dmem_after", 32'(wens), 32'(W_RUN));
        check("dmem_stall_cnt", 32'(hz.stall_cnt), 32'd5);

        // Halt and drain.
        hz.d_halt = 1'b1;
        #1 check("halt_decode", 32'(wens), 32'(W_BUBBLE));
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            hz.w_halt = (i == 2);
            #1 check("drain", 32'(wens), 32'(W_BUBBLE));
            check("drain_halted", 32'(hz.halted), 32'd0);
            tick();
        end
        idle();
        #1 check("halted_wens", 32'(wens), 32'(W_NONE));
        check("halted_flag", 32'(hz.halted), 32'd1);
        hz.d_branch_taken = 1'b1;
        load_use(4'd2, 4'd2, 1'b1);
        tick();
        check("halted_flush_hold", 32'(hz.flush_cnt), 32'd5);
        check("halted_stall_hold", 32'(hz.stall_cnt), 32'd5);
        check("halted_stays", 32'(hz.halted), 32'd1);
        idle();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 check("rerst_halted", 32'(hz.halted), 32'd0);
        check("rerst_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rerst_flush_cnt", 32'(hz.flush_cnt), 32'd0);
        check("rerst_wens", 32'(wens), 32'(W_RUN));

        // Counter saturation, then reset mid-stall.
        load_use(4'd9, 4'd9, 1'b1);
        repeat (65540) tick();
        check("stall_sat", 32'(hz.stall_cnt), 32'h0000_FFFF);
        rst = 1'b1;
        #1 check("rst_mid_stall_wens", 32'(wens), 32'(W_NONE));
        tick();
        rst = 1'b0;
        idle();
        #1 check("rst_mid_stall_cnt", 32'(hz.stall_cnt), 32'd0);
        check("rst_mid_stall_run", 32'(wens), 32'(W_RUN));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
